// File: rtl/vga_grid_cursor_ctrl.sv
// Grid cursor / mark controller for the VGA game: moves a cursor over a
// GRID_COLS x GRID_ROWS cell grid and emits registered per-pixel colour codes.
module vga_grid_cursor_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int GRID_COLS = 3,
    parameter int GRID_ROWS = 3,
    parameter int COLOR_W   = 3,
    parameter int CNT_W     = 16,
    localparam int COL_W    = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1,
    localparam int ROW_W    = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1,
    localparam int N_CELLS  = GRID_COLS * GRID_ROWS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CNT_W-1:0]   h_count,
    input  logic [CNT_W-1:0]   v_count,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_sel,
    output logic [COL_W-1:0]   cursor_col,
    output logic [ROW_W-1:0]   cursor_row,
    output logic [N_CELLS-1:0] mark_mask,
    output logic [COLOR_W-1:0] color_red,
    output logic [COLOR_W-1:0] color_green,
    output logic [COLOR_W-1:0] color_blue
);

    localparam int CELL_W = H_ACTIVE / GRID_COLS;
    localparam int CELL_H = V_ACTIVE / GRID_ROWS;
    localparam logic [COL_W-1:0]   COL_LAST = COL_W'(GRID_COLS - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST = ROW_W'(GRID_ROWS - 1);
    localparam logic [COLOR_W-1:0] C_MAX    = {COLOR_W{1'b1}};

    // Button vector order: {sel, right, left, down, up}
    logic [4:0] btn_now;
    logic [4:0] prev_q;
    logic [4:0] press;

    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [N_CELLS-1:0] mark_q, mark_d;

    logic [COLOR_W-1:0] red_q, red_d;
    logic [COLOR_W-1:0] green_q, green_d;
    logic [COLOR_W-1:0] blue_q, blue_d;

    logic               in_active;
    logic               on_line;
    logic [COL_W-1:0]   pix_col;
    logic [ROW_W-1:0]   pix_row;
    logic               pix_cursor;
    logic               pix_marked;

    assign btn_now = {btn_sel, btn_right, btn_left, btn_down, btn_up};
    assign press   = btn_now & ~prev_q;

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        mark_d = mark_q;
        if (press[0]) begin
            row_d = (row_q == '0) ? ROW_LAST : row_q - ROW_W'(1);
        end else if (press[1]) begin
            row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
        end else if (press[2]) begin
            col_d = (col_q == '0) ? COL_LAST : col_q - COL_W'(1);
        end else if (press[3]) begin
            col_d = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
        end
        // Select acts on the cursor as it stood before this cycle's move.
        for (int r = 0; r < GRID_ROWS; r++) begin
            for (int c = 0; c < GRID_COLS; c++) begin
                if (press[4] && row_q == ROW_W'(r) && col_q == COL_W'(c)) begin
                    mark_d[r*GRID_COLS+c] = ~mark_q[r*GRID_COLS+c];
                end
            end
        end
    end

    // Cell lookup by comparing against elaboration-time boundary constants.
    always_comb begin
        in_active = (h_count < CNT_W'(H_ACTIVE)) && (v_count < CNT_W'(V_ACTIVE));
        on_line   = 1'b0;
        pix_col   = '0;
        pix_row   = '0;
        for (int k = 1; k < GRID_COLS; k++) begin
            if (h_count == CNT_W'(k * CELL_W)) on_line = 1'b1;
            if (h_count >  CNT_W'(k * CELL_W)) pix_col = pix_col + COL_W'(1);
        end
        for (int k = 1; k < GRID_ROWS; k++) begin
            if (v_count == CNT_W'(k * CELL_H)) on_line = 1'b1;
            if (v_count >  CNT_W'(k * CELL_H)) pix_row = pix_row + ROW_W'(1);
        end
        pix_cursor = (pix_col == col_q) && (pix_row == row_q);
        pix_marked = 1'b0;
        for (int r = 0; r < GRID_ROWS; r++) begin
            for (int c = 0; c < GRID_COLS; c++) begin
                if (pix_row == ROW_W'(r) && pix_col == COL_W'(c) && mark_q[r*GRID_COLS+c]) begin
                    pix_marked = 1'b1;
                end
            end
        end
    end

    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (in_active && !on_line) begin
            if (pix_cursor && pix_marked) begin
                red_d  = C_MAX;
                blue_d = C_MAX;
            end else if (pix_cursor) begin
                red_d = C_MAX;
            end else if (pix_marked) begin
                blue_d = C_MAX;
            end else begin
                red_d   = C_MAX;
                green_d = C_MAX;
                blue_d  = C_MAX;
            end
        end
    end

    // History loads live levels in reset so a held button never counts as a press.
    always_ff @(posedge clk) begin
        prev_q <= btn_now;
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            mark_q  <= '0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            mark_q  <= mark_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign cursor_col  = col_q;
    assign cursor_row  = row_q;
    assign mark_mask   = mark_q;
    assign color_red   = red_q;
    assign color_green = green_q;
    assign color_blue  = blue_q;

endmodule

// File: tb/tb_vga_grid_cursor_ctrl.sv
// Bench for vga_grid_cursor_ctrl: a 3x3 and a 4x2 instance share stimulus and
// are compared every cycle against an arithmetic reference model.
module tb_vga_grid_cursor_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] h_count, v_count;
    logic        btn_up, btn_down, btn_left, btn_right, btn_sel;

    logic [1:0] c1_col, c1_row;
    logic [8:0] m1_mask;
    logic [2:0] r1, g1, b1;

    logic [1:0] c2_col;
    logic [0:0] c2_row;
    logic [7:0] m2_mask;
    logic [2:0] r2, g2, b2;

    int n_checks = 0;
    int n_errors = 0;

    int          m_col [2];
    int          m_row [2];
    logic [31:0] m_mask [2];
    logic [4:0]  m_prev;
    int          cols_of [2] = '{3, 4};
    int          rows_of [2] = '{3, 2};
    logic [8:0]  exp_q [$];

    int bnd_h [18] = '{0, 159, 160, 161, 212, 213, 214, 319, 320, 321, 425, 426, 427, 479, 480, 481, 639, 640};
    int bnd_v [12] = '{0, 159, 160, 161, 239, 240, 241, 319, 320, 321, 479, 480};

    always #20 clk = ~clk;

    vga_grid_cursor_ctrl dut1 (
        .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_sel(btn_sel),
        .cursor_col(c1_col), .cursor_row(c1_row), .mark_mask(m1_mask),
        .color_red(r1), .color_green(g1), .color_blue(b1)
    );

    vga_grid_cursor_ctrl #(.GRID_COLS(4), .GRID_ROWS(2)) dut2 (
        .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_sel(btn_sel),
        .cursor_col(c2_col), .cursor_row(c2_row), .mark_mask(m2_mask),
        .color_red(r2), .color_green(g2), .color_blue(b2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] ref_color(input int cols, input int rows, input int h, input int v,
                                             input int ccol, input int crow, input logic [31:0] mask);
        int cw = 640 / cols;
        int ch = 480 / rows;
        int col, row;
        logic cur, mk;
        if (h >= 640 || v >= 480) return 9'd0;
        if (h % cw == 0 && h / cw >= 1 && h / cw <= cols - 1) return 9'd0;
        if (v % ch == 0 && v / ch >= 1 && v / ch <= rows - 1) return 9'd0;
        col = h / cw;
        if (col > cols - 1) col = cols - 1;
        row = v / ch;
        if (row > rows - 1) row = rows - 1;
        cur = (col == ccol) && (row == crow);
        mk  = mask[row*cols+col];
        if (cur && mk) return {3'd7, 3'd0, 3'd7};
        if (cur)       return {3'd7, 3'd0, 3'd0};
        if (mk)        return {3'd0, 3'd0, 3'd7};
        return {3'd7, 3'd7, 3'd7};
    endfunction

    task automatic set_btns(input logic [4:0] b);
        {btn_sel, btn_right, btn_left, btn_down, btn_up} = b;
    endtask

    // One clock: model follows the edge, then every output is compared.
    task automatic tick();
        logic [4:0] btn, press;
        int idx;
        @(posedge clk);
        btn = {btn_sel, btn_right, btn_left, btn_down, btn_up};
        press = btn & ~m_prev;
        for (int d = 0; d < 2; d++) begin
            if (rst) exp_q.push_back(9'd0);
            else exp_q.push_back(ref_color(cols_of[d], rows_of[d], int'(h_count), int'(v_count),
                                           m_col[d], m_row[d], m_mask[d]));
            if (rst) begin
                m_col[d]  = 0;
                m_row[d]  = 0;
                m_mask[d] = '0;
            end else begin
                if (press[4]) begin
                    idx = m_row[d] * cols_of[d] + m_col[d];
                    m_mask[d][idx] = ~m_mask[d][idx];
                end
                if (press[0])      m_row[d] = (m_row[d] + rows_of[d] - 1) % rows_of[d];
                else if (press[1]) m_row[d] = (m_row[d] + 1) % rows_of[d];
                else if (press[2]) m_col[d] = (m_col[d] + cols_of[d] - 1) % cols_of[d];
                else if (press[3]) m_col[d] = (m_col[d] + 1) % cols_of[d];
            end
        end
        m_prev = btn;
        #1;
        check_eq("col_3x3", 32'(c1_col), 32'(m_col[0]));
        check_eq("row_3x3", 32'(c1_row), 32'(m_row[0]));
        check_eq("mask_3x3", 32'(m1_mask), m_mask[0]);
        check_eq("rgb_3x3", 32'({r1, g1, b1}), 32'(exp_q.pop_front()));
        check_eq("col_4x2", 32'(c2_col), 32'(m_col[1]));
        check_eq("row_4x2", 32'(c2_row), 32'(m_row[1]));
        check_eq("mask_4x2", 32'(m2_mask), m_mask[1]);
        check_eq("rgb_4x2", 32'({r2, g2, b2}), 32'(exp_q.pop_front()));
        @(negedge clk);
    endtask

    task automatic pulse(input logic [4:0] b);
        set_btns(b);
        tick();
        set_btns(5'b0);
        tick();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_col[d] = 0;
            m_row[d] = 0;
            m_mask[d] = '0;
        end
        m_prev = '0;
        rst = 1'b1;
        h_count = 16'd0;
        v_count = 16'd0;
        set_btns(5'b01000);
        @(negedge clk);

        // Reset with right held: no press on release of reset.
        repeat (3) tick();
        check_eq("rst_rgb", 32'({r1, g1, b1}), 32'd0);
        rst = 1'b0;
        tick();
        set_btns(5'b0);
        repeat (10) tick();
        check_eq("rst_col", 32'(c1_col), 32'd0);
        check_eq("rst_row", 32'(c1_row), 32'd0);
        check_eq("rst_mask", 32'(m1_mask), 32'd0);

        // Right x3 with wrap, then up wraps row.
        pulse(5'b01000);
        check_eq("right1", 32'(c1_col), 32'd1);
        pulse(5'b01000);
        check_eq("right2", 32'(c1_col), 32'd2);
        pulse(5'b01000);
        check_eq("right3_wrap", 32'(c1_col), 32'd0);
        pulse(5'b00001);
        check_eq("up_wrap", 32'(c1_row), 32'd2);

        // Holding never repeats.
        set_btns(5'b01000);
        repeat (50) tick();
        set_btns(5'b0);
        tick();
        check_eq("hold_once", 32'(c1_col), 32'd1);

        // Up to row 1, then up+left+sel together at (1,1).
        pulse(5'b00001);
        check_eq("at_row1", 32'(c1_row), 32'd1);
        pulse(5'b10101);
        check_eq("combo_row", 32'(c1_row), 32'd0);
        check_eq("combo_col", 32'(c1_col), 32'd1);
        check_eq("combo_mark4", 32'(m1_mask[4]), 32'd1);

        // Pixel colours at cursor (0,0), cell 0 unmarked.
        pulse(5'b00100);
        check_eq("back_col0", 32'(c1_col), 32'd0);
        h_count = 16'd100; v_count = 16'd100;
        tick();
        check_eq("pix_cursor", 32'({r1, g1, b1}), 32'({3'd7, 3'd0, 3'd0}));
        h_count = 16'd213;
        tick();
        check_eq("pix_line", 32'({r1, g1, b1}), 32'd0);
        h_count = 16'd300;
        tick();
        check_eq("pix_white", 32'({r1, g1, b1}), 32'({3'd7, 3'd7, 3'd7}));
        h_count = 16'd650;
        tick();
        check_eq("pix_blank", 32'({r1, g1, b1}), 32'd0);
        h_count = 16'd100;
        pulse(5'b10000);
        check_eq("pix_cur_mark", 32'({r1, g1, b1}), 32'({3'd7, 3'd0, 3'd7}));

        // Mid-frame reset: one black cycle, then normal output.
        rst = 1'b1;
        tick();
        check_eq("midrst_black", 32'({r1, g1, b1}), 32'd0);
        rst = 1'b0;
        tick();
        check_eq("midrst_resume", 32'({r1, g1, b1}), 32'({3'd7, 3'd0, 3'd0}));

        // 4x2 geometry: line at 160, cell col 1 at 161, left wraps to col 3.
        h_count = 16'd160; v_count = 16'd10;
        tick();
        check_eq("g42_line", 32'({r2, g2, b2}), 32'd0);
        h_count = 16'd161;
        tick();
        check_eq("g42_cell1", 32'({r2, g2, b2}), 32'({3'd7, 3'd7, 3'd7}));
        pulse(5'b00100);
        check_eq("g42_left_wrap", 32'(c2_col), 32'd3);
        check_eq("g33_left_wrap", 32'(c1_col), 32'd2);

        // Random traffic with occasional reset and boundary-biased coordinates.
        repeat (1500) begin
            rst = ($urandom_range(0, 99) == 0);
            set_btns(5'($urandom_range(0, 31) & $urandom_range(0, 31)));
            if ($urandom_range(0, 1) == 0) h_count = 16'(bnd_h[$urandom_range(0, 17)]);
            else h_count = 16'($urandom_range(0, 799));
            if ($urandom_range(0, 1) == 0) v_count = 16'(bnd_v[$urandom_range(0, 11)]);
            else v_count = 16'($urandom_range(0, 524));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_grid_cursor_ctrl.md
Name: vga_grid_cursor_ctrl

Overview:
- Parametrised successor of the fixed 3x3 button/grid colour logic in the VGA game top level.
- Divides the active display into a GRID_COLS x GRID_ROWS grid of cells and tracks a cursor cell moved by edge-detected direction buttons.
- Keeps a per-cell mark bitmap toggled by a select button and produces registered per-pixel colour codes for the colour decoders.
- Sits between the VGA timing counters and button synchronisers on the input side, and the deco_red/green/blue decoders on the output side.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- GRID_COLS, 3, grid columns (>=1); CELL_W = H_ACTIVE/GRID_COLS (integer divide).
- GRID_ROWS, 3, grid rows (>=1); CELL_H = V_ACTIVE/GRID_ROWS.
- COLOR_W, 3, width of each colour-code output.
- CNT_W, 16, width of the pixel counters.

Ports:
- clk  in  1  pixel clock (25 MHz domain).
- rst  in  1  synchronous, active-high reset.
- h_count  in  CNT_W  current horizontal pixel count.
- v_count  in  CNT_W  current vertical line count.
- btn_up, btn_down, btn_left, btn_right, btn_sel  in  1 each  already-synchronised button levels, active-high.
- cursor_col  out  $clog2(GRID_COLS) (min 1)  cursor column.
- cursor_row  out  $clog2(GRID_ROWS) (min 1)  cursor row.
- mark_mask  out  GRID_COLS*GRID_ROWS  marked cells; bit index = row*GRID_COLS+col.
- color_red, color_green, color_blue  out  COLOR_W each  registered colour codes.

Behaviour:
- Reset (rst=1 at a clk edge):
  - cursor (0,0); mark_mask all 0; all colour outputs 0.
  - Button history registers load the current button levels, so a button held through reset does not produce a press.
- Edge detect: press_x = btn_x & ~prev_x. prev_x updates every cycle.
- Cursor register updates on the same edge that first samples a button high. Buttons must be released and pressed again to repeat; holding never repeats.
- Move priority when several presses occur in one cycle: up > down > left > right. At most one move per cycle; lower-priority presses that cycle are discarded.
- Moves wrap around:
  - up at row 0 -> GRID_ROWS-1; down at GRID_ROWS-1 -> 0.
  - left at col 0 -> GRID_COLS-1; right at GRID_COLS-1 -> 0.
- Select: press_sel toggles mark_mask[cursor index], using the cursor value before any move in that same cycle. A move and a select in the same cycle are both performed.
- Pixel path, 1-cycle latency (colours at edge N+1 reflect counts sampled at edge N, plus cursor/marks as held before edge N):
  - Region selection, first match wins:
    - Blank: h_count>=H_ACTIVE or v_count>=V_ACTIVE -> all 0.
    - Grid line: h_count==k*CELL_W for k in 1..GRID_COLS-1, or v_count==k*CELL_H for k in 1..GRID_ROWS-1 -> all 0 (black).
    - Cell, otherwise: col = number of k (1..GRID_COLS-1) with k*CELL_W < h_count, clamped to GRID_COLS-1; row likewise on v_count.
  - Cell colour, first match wins:
    - Cursor cell and marked -> red=max, green=0, blue=max.
    - Cursor cell -> red=max, 0, 0.
    - Marked -> 0, 0, blue=max.
    - Otherwise -> all max (white). max = all ones of COLOR_W.
- No dividers in the pixel path. Boundary constants are computed at elaboration; cell lookup uses comparators only.
- Reset asserted mid-frame: colours are 0 in the cycle after the reset edge, and normal output resumes on the following cycle.

Test Plan:
- Reset with btn_right held, release, wait 10 cycles -> cursor_col=0, cursor_row=0, mark_mask=0, colours 0 during reset.
- Defaults, cursor (0,0): press right 3 times (1-cycle pulses with gaps) -> cursor_col sequence 1,2,0. Press up once -> cursor_row=2.
- btn_right held high for 50 cycles -> exactly one move, cursor_col 0->1.
- Same cycle: up+left+sel rising at cursor (1,1) -> cursor_row=0, cursor_col=1, mark_mask bit 4 set.
- Cursor (0,0), cell 0 unmarked, drive (h,v)=(100,100) -> next cycle colours = (7,0,0). (213,100) -> (0,0,0). (300,100) -> (7,7,7). (650,100) -> (0,0,0). Mark cell 0, (100,100) -> (7,0,7).
- Parameter set GRID_COLS=4, GRID_ROWS=2: (160,10) -> black line; (161,10) -> cell col 1. Press left at col 0 -> cursor_col=3.
